// File: rtl/divider_if.sv
// rtl/divider_if.sv - operand/result handshake bundle for the iterative divider
`ifndef XLEN
`define XLEN 64
`endif

interface divider_if #(
    parameter int WIDTH = `XLEN
) ();
    logic             iValidIn;
    logic             oReady;
    logic             oValid;
    logic             iReadyOut;
    logic             iFlush;
    logic             iSigned;
    logic [WIDTH-1:0] iDividend;
    logic [WIDTH-1:0] iDivisor;
    logic [WIDTH-1:0] oQuotient;
    logic [WIDTH-1:0] oRemainder;

    modport master (
        output iValidIn, iReadyOut, iFlush, iSigned, iDividend, iDivisor,
        input  oReady, oValid, oQuotient, oRemainder
    );

    modport slave (
        input  iValidIn, iReadyOut, iFlush, iSigned, iDividend, iDivisor,
        output oReady, oValid, oQuotient, oRemainder
    );
endinterface

// File: rtl/divider.sv
// rtl/divider.sv - radix-2 restoring divider, signed/unsigned, one quotient bit per cycle
`ifndef XLEN
`define XLEN 64
`endif

module divider #(
    parameter int WIDTH = `XLEN
) (
    input  logic     clk,
    input  logic     rst,
    divider_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic             accept;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   rem_sh, diff;

    assign bus.oReady     = (state_q == IDLE) || (state_q == DONE && bus.iReadyOut);
    assign bus.oValid     = (state_q == DONE);
    assign bus.oQuotient  = quo_q;
    assign bus.oRemainder = rem_q;

    assign accept = bus.iValidIn && bus.oReady && !bus.iFlush;
    assign a_neg  = bus.iSigned && bus.iDividend[WIDTH-1];
    assign b_neg  = bus.iSigned && bus.iDivisor[WIDTH-1];
    assign abs_a  = a_neg ? -bus.iDividend : bus.iDividend;
    assign abs_b  = b_neg ? -bus.iDivisor  : bus.iDivisor;

    // Partial remainder is widened by one bit so the trial subtraction's sign is its MSB.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, div_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        div_d   = div_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;

        if (bus.iFlush) begin
            state_d = IDLE;
        end else if (accept) begin
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
            div_d  = abs_b;
            if (bus.iDivisor == '0) begin
                state_d = DONE;
                quo_d   = '1;
                rem_d   = bus.iDividend;
            end else if (bus.iSigned && bus.iDividend == MIN_NEG && bus.iDivisor == '1) begin
                state_d = DONE;
                quo_d   = bus.iDividend;
                rem_d   = '0;
            end else begin
                state_d = CALC;
                cnt_d   = CW'(WIDTH - 1);
                quo_d   = abs_a;
                rem_d   = '0;
            end
        end else begin
            case (state_q)
                CALC: begin
                    quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                    rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                    if (cnt_q == '0) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                FIX: begin
                    if (qneg_q) quo_d = -quo_q;
                    if (rneg_q) rem_d = -rem_q;
                    state_d = DONE;
                end
                DONE: begin
                    if (bus.iReadyOut) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end
endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed self-checking bench for divider
module tb_divider;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    divider_if #(.WIDTH(64)) bus ();

    divider #(.WIDTH(64)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sg;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } vec_t;

    task automatic start_op(input logic sg, input logic [63:0] a, input logic [63:0] b);
        bus.iSigned   = sg;
        bus.iDividend = a;
        bus.iDivisor  = b;
        bus.iValidIn  = 1'b1;
        @(posedge clk); #1;
        bus.iValidIn  = 1'b0;
        bus.iSigned   = ~sg;
        bus.iDividend = 64'hDEAD_BEEF_0BAD_F00D;
        bus.iDivisor  = 64'h0000_0000_0000_0005;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 1;
        while (!bus.oValid && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus.oValid) cyc = -1;
    endtask

    task automatic retire();
        bus.iReadyOut = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.oValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.oValid); end
        total++; if (bus.oQuotient !== 64'd0) begin bad++; $display("FAIL reset_quo got=%h want=0", bus.oQuotient); end
        total++; if (bus.oRemainder !== 64'd0) begin bad++; $display("FAIL reset_rem got=%h want=0", bus.oRemainder); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (bus.oReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.oReady); end
    endtask

    task automatic test_unsigned();
        vec_t tbl [4];
        int   cyc;
        tbl[0] = '{1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 66};
        tbl[1] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66};
        tbl[2] = '{1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000, 66};
        tbl[3] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'h7FFF_FFFF_FFFF_FFFC, 64'd1, 66};
        for (int i = 0; i < 4; i++) begin
            start_op(tbl[i].sg, tbl[i].a, tbl[i].b);
            wait_valid(cyc);
            total++; if (cyc != tbl[i].lat) begin bad++; $display("FAIL u%0d_latency got=%0d want=%0d", i, cyc, tbl[i].lat); end
            total++; if (bus.oQuotient !== tbl[i].q) begin bad++; $display("FAIL u%0d_quo got=%h want=%h", i, bus.oQuotient, tbl[i].q); end
            total++; if (bus.oRemainder !== tbl[i].r) begin bad++; $display("FAIL u%0d_rem got=%h want=%h", i, bus.oRemainder, tbl[i].r); end
            retire();
        end
    endtask

    task automatic test_signed();
        vec_t tbl [4];
        int   cyc;
        tbl[0] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66};
        tbl[1] = '{1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66};
        tbl[2] = '{1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        tbl[3] = '{1'b1, 64'h8000_0000_0000_0000, 64'd2, 64'hC000_0000_0000_0000, 64'd0, 66};
        for (int i = 0; i < 4; i++) begin
            start_op(tbl[i].sg, tbl[i].a, tbl[i].b);
            wait_valid(cyc);
            total++; if (cyc != tbl[i].lat) begin bad++; $display("FAIL s%0d_latency got=%0d want=%0d", i, cyc, tbl[i].lat); end
            total++; if (bus.oQuotient !== tbl[i].q) begin bad++; $display("FAIL s%0d_quo got=%h want=%h", i, bus.oQuotient, tbl[i].q); end
            total++; if (bus.oRemainder !== tbl[i].r) begin bad++; $display("FAIL s%0d_rem got=%h want=%h", i, bus.oRemainder, tbl[i].r); end
            retire();
        end
    endtask

    task automatic test_special();
        vec_t tbl [3];
        int   cyc;
        tbl[0] = '{1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1};
        tbl[1] = '{1'b1, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 1};
        tbl[2] = '{1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, 1};
        for (int i = 0; i < 3; i++) begin
            start_op(tbl[i].sg, tbl[i].a, tbl[i].b);
            wait_valid(cyc);
            total++; if (cyc != tbl[i].lat) begin bad++; $display("FAIL sp%0d_latency got=%0d want=%0d", i, cyc, tbl[i].lat); end
            total++; if (bus.oQuotient !== tbl[i].q) begin bad++; $display("FAIL sp%0d_quo got=%h want=%h", i, bus.oQuotient, tbl[i].q); end
            total++; if (bus.oRemainder !== tbl[i].r) begin bad++; $display("FAIL sp%0d_rem got=%h want=%h", i, bus.oRemainder, tbl[i].r); end
            retire();
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bus.iReadyOut = 1'b0;
        start_op(1'b0, 64'd100, 64'd7);
        wait_valid(cyc);
        total++; if (cyc != 66) begin bad++; $display("FAIL bp_latency got=%0d want=66", cyc); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++; if (bus.oValid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid c%0d got=%b want=1", i, bus.oValid); end
            total++; if (bus.oQuotient !== 64'd14 || bus.oRemainder !== 64'd2) begin
                bad++; $display("FAIL bp_hold_data c%0d got=%h/%h want=e/2", i, bus.oQuotient, bus.oRemainder);
            end
            total++; if (bus.oReady !== 1'b0) begin bad++; $display("FAIL bp_hold_ready c%0d got=%b want=0", i, bus.oReady); end
        end
        bus.iReadyOut = 1'b1;
        bus.iSigned   = 1'b0;
        bus.iDividend = 64'd1000;
        bus.iDivisor  = 64'd10;
        bus.iValidIn  = 1'b1;
        #1;
        total++; if (bus.oReady !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", bus.oReady); end
        @(posedge clk); #1;
        bus.iValidIn = 1'b0;
        total++; if (bus.oValid !== 1'b0) begin bad++; $display("FAIL b2b_retired got=%b want=0", bus.oValid); end
        wait_valid(cyc);
        total++; if (cyc != 66) begin bad++; $display("FAIL b2b_latency got=%0d want=66", cyc); end
        total++; if (bus.oQuotient !== 64'd100) begin bad++; $display("FAIL b2b_quo got=%h want=64", bus.oQuotient); end
        total++; if (bus.oRemainder !== 64'd0) begin bad++; $display("FAIL b2b_rem got=%h want=0", bus.oRemainder); end
        retire();
    endtask

    task automatic test_abort(input bit use_rst);
        int cyc;
        bit seen;
        start_op(1'b0, 64'd1000, 64'd3);
        repeat (29) begin @(posedge clk); #1; end
        if (use_rst) begin
            rst = 1'b1;
        end else begin
            bus.iFlush    = 1'b1;
            bus.iValidIn  = 1'b1;
            bus.iSigned   = 1'b0;
            bus.iDividend = 64'd5;
            bus.iDivisor  = 64'd1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.iFlush   = 1'b0;
        bus.iValidIn = 1'b0;
        total++; if (bus.oValid !== 1'b0) begin bad++; $display("FAIL abort%0d_valid got=%b want=0", use_rst, bus.oValid); end
        total++; if (bus.oReady !== 1'b1) begin bad++; $display("FAIL abort%0d_idle got=%b want=1", use_rst, bus.oReady); end
        seen = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (bus.oValid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort%0d_no_valid got=%b want=0", use_rst, seen); end
        start_op(1'b0, 64'd9, 64'd3);
        wait_valid(cyc);
        total++; if (cyc != 66) begin bad++; $display("FAIL abort%0d_after_latency got=%0d want=66", use_rst, cyc); end
        total++; if (bus.oQuotient !== 64'd3) begin bad++; $display("FAIL abort%0d_after_quo got=%h want=3", use_rst, bus.oQuotient); end
        total++; if (bus.oRemainder !== 64'd0) begin bad++; $display("FAIL abort%0d_after_rem got=%h want=0", use_rst, bus.oRemainder); end
        retire();
    endtask

    task automatic test_reset_done();
        bit seen;
        bus.iReadyOut = 1'b0;
        start_op(1'b0, 64'h1234, 64'd0);
        total++; if (bus.oValid !== 1'b1) begin bad++; $display("FAIL rdone_pre got=%b want=1", bus.oValid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (bus.oValid !== 1'b0) begin bad++; $display("FAIL rdone_valid got=%b want=0", bus.oValid); end
        total++; if (bus.oQuotient !== 64'd0 || bus.oRemainder !== 64'd0) begin
            bad++; $display("FAIL rdone_data got=%h/%h want=0/0", bus.oQuotient, bus.oRemainder);
        end
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.oValid) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rdone_no_valid got=%b want=0", seen); end
        bus.iReadyOut = 1'b1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.iValidIn  = 1'b0;
        bus.iReadyOut = 1'b1;
        bus.iFlush    = 1'b0;
        bus.iSigned   = 1'b0;
        bus.iDividend = '0;
        bus.iDivisor  = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_back_to_back();
        test_abort(1'b0);
        test_abort(1'b1);
        test_reset_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
- REQ-001: Parameter WIDTH, default `XLEN (64); operand and result width in bits.
- REQ-002: clk  input  1  sole clock; all state updates on its rising edge.
- REQ-003: rst  input  1  reset, synchronous, active-high.
- REQ-004: iValidIn  input  1  upstream has a valid operand pair.
- REQ-005: oReady  output  1  divider can accept operands this cycle.
- REQ-006: oValid  output  1  oQuotient/oRemainder are valid.
- REQ-007: iReadyOut  input  1  downstream accepts the result this cycle.
- REQ-008: iFlush  input  1  abort any in-flight or held operation.
- REQ-009: iSigned  input  1  1 = two's-complement division, 0 = unsigned.
- REQ-010: iDividend  input  WIDTH  dividend.
- REQ-011: iDivisor  input  WIDTH  divisor.
- REQ-012: oQuotient  output  WIDTH  quotient, truncated toward zero.
- REQ-013: oRemainder  output  WIDTH  remainder; sign follows the dividend.

Function
- REQ-014: The FSM SHALL have states IDLE, CALC, FIX and DONE.
- REQ-015: An operation SHALL be accepted on a rising edge where iValidIn && oReady && !iFlush.
- REQ-016: oReady SHALL equal (state==IDLE) || (state==DONE && iReadyOut); acceptance is blocked in CALC and FIX.
- REQ-017: On accept, the divider SHALL latch |dividend|, |divisor| (abs only when iSigned), the quotient sign (dividend MSB ^ divisor MSB) and the remainder sign (dividend MSB).
- REQ-018: On accept with divisor==0, the divider SHALL go directly to DONE with quotient = all ones and remainder = dividend.
- REQ-019: On accept with iSigned, dividend==2^(WIDTH-1) and divisor==all ones, the divider SHALL go directly to DONE with quotient = dividend and remainder = 0.
- REQ-020: On any other accept, the divider SHALL go to CALC and load a WIDTH-1 iteration counter.
- REQ-021: In CALC, each cycle SHALL perform one restoring step: shift {rem,quo} left by 1, trial-subtract the divisor from the WIDTH+1-bit partial remainder, and set the quotient LSB to 1 if the result is non-negative (keeping the difference) or 0 otherwise (restoring).
- REQ-022: CALC SHALL last exactly WIDTH cycles (counter reaches 0), then go to FIX.
- REQ-023: FIX SHALL last 1 cycle: negate the quotient if the quotient sign is 1 and negate the remainder if the remainder sign is 1 (signed mode only); then go to DONE.
- REQ-024: Normal-path latency: oValid SHALL be first high WIDTH+2 cycles after the accept edge; special-case latency (REQ-018/019) is 1 cycle.
- REQ-025: oValid SHALL be high only in DONE; outputs SHALL hold stable while oValid && !iReadyOut.
- REQ-026: In DONE with iReadyOut, the result SHALL retire: the FSM enters CALC/DONE for a new accept in the same cycle (back-to-back), or IDLE otherwise.
- REQ-027: iFlush SHALL force IDLE on the next edge from any state and discard the result; flush has priority over accept and retire in the same cycle; oValid SHALL be low the cycle after the flush.
- REQ-028: Inputs SHALL be sampled only at the accept edge; operand changes afterwards SHALL not affect the result.
- REQ-029: Arithmetic SHALL be exact for all 2^(2*WIDTH) operand pairs in both modes.

Reset
- REQ-030: While rst is high at a clock edge, the FSM SHALL enter IDLE, with oValid=0, oQuotient=0 and oRemainder=0; oReady SHALL be 1 from the first cycle after reset.
- REQ-031: Reset asserted mid-CALC or in DONE SHALL discard the operation; no oValid SHALL follow the release of reset.

Verification
- REQ-032: Unsigned 100 / 7 -> oValid after 66 cycles, quotient 14, remainder 2.
- REQ-033: Signed -7 / 2 -> quotient -3 (0xFFFF_FFFF_FFFF_FFFD), remainder -1; signed 7 / -2 -> quotient -3, remainder 1.
- REQ-034: Divisor 0, dividend 0x1234 (either mode) -> oValid after 1 cycle, quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 0x1234.
- REQ-035: Signed 0x8000_0000_0000_0000 / -1 -> oValid after 1 cycle, quotient 0x8000_0000_0000_0000, remainder 0.
- REQ-036: Hold iReadyOut=0 for 10 cycles in DONE -> outputs stable and oReady=0; then assert iReadyOut with iValidIn high -> retire and accept in the same cycle, and the next oValid follows 66 cycles later.
- REQ-037: Assert iFlush (and separately rst) on CALC cycle 30 -> IDLE next cycle, oValid never asserts, and a following 9 / 3 returns quotient 3, remainder 0.
